// File: rtl/coax_tx.sv
// Coax Manchester transmitter: start sequence, line-code violation, 12-bit
// words (sync, 10 data bits MSB first, even parity) and an end sequence.
module coax_tx #(
  parameter int unsigned CLOCKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] data,
  input  logic       load_strobe,
  output logic       ready,
  output logic       active,
  output logic       tx
);

  localparam int unsigned H  = CLOCKS_PER_BIT / 2;
  localparam int unsigned CW = $clog2(CLOCKS_PER_BIT * 12 + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_VIOL  = 3'd2;
  localparam logic [2:0] S_WORD  = 3'd3;
  localparam logic [2:0] S_END   = 3'd4;

  localparam logic [CW-1:0] C_HALF      = CW'(H);
  localparam logic [CW-1:0] C_BIT_LAST  = CW'(CLOCKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_VIOL_HALF = CW'(3 * H);
  localparam logic [CW-1:0] C_VIOL_LAST = CW'(3 * CLOCKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_END_LAST  = CW'(2 * CLOCKS_PER_BIT - 1);

  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_bit;
  logic [11:0]   r_shift;
  logic [9:0]    r_hold;
  logic          r_full;
  logic          r_tx;
  logic          r_active;
  logic          r_ready;

  logic [2:0]    w_state;
  logic [CW-1:0] w_cnt;
  logic [3:0]    w_bit;
  logic [11:0]   w_shift;
  logic [9:0]    w_hold;
  logic          w_full;
  logic          w_tx;
  logic          w_active;
  logic          w_ready;
  logic          w_accept;
  logic [11:0]   w_word;

  // Next-state logic; outputs are derived from the next state so they register in step.
  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt + CW'(1);
    w_bit    = r_bit;
    w_shift  = r_shift;
    w_hold   = r_hold;
    w_full   = r_full;
    w_tx     = 1'b0;
    w_active = 1'b0;
    w_ready  = 1'b0;
    w_accept = load_strobe & r_ready;
    w_word   = {1'b1, r_hold, ^r_hold};

    if (w_accept) begin
      w_hold = data;
      w_full = 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        w_cnt = '0;
        w_bit = 4'd0;
        if (w_accept || r_full) w_state = S_START;
      end
      S_START: begin
        if (r_cnt == C_BIT_LAST) begin
          w_cnt = '0;
          if (r_bit == 4'd4) begin
            w_state = S_VIOL;
            w_bit   = 4'd0;
          end else begin
            w_bit = r_bit + 4'd1;
          end
        end
      end
      S_VIOL: begin
        if (r_cnt == C_VIOL_LAST) begin
          w_cnt = '0;
          if (r_full) begin
            w_state = S_WORD;
            w_shift = w_word;
            w_full  = 1'b0;
          end else begin
            w_state = S_END;
          end
        end
      end
      S_WORD: begin
        if (r_cnt == C_BIT_LAST) begin
          w_cnt = '0;
          if (r_bit == 4'd11) begin
            // Word boundary: chain the held word with no gap, else close the frame.
            w_bit = 4'd0;
            if (r_full) begin
              w_shift = w_word;
              w_full  = 1'b0;
            end else begin
              w_state = S_END;
            end
          end else begin
            w_bit   = r_bit + 4'd1;
            w_shift = {r_shift[10:0], 1'b0};
          end
        end
      end
      S_END: begin
        if (r_cnt == C_END_LAST) begin
          w_cnt   = '0;
          w_state = S_IDLE;
        end
      end
      default: begin
        w_state = S_IDLE;
        w_cnt   = '0;
      end
    endcase

    case (w_state)
      S_START: w_tx = (w_cnt < C_HALF);
      S_VIOL:  w_tx = (w_cnt < C_VIOL_HALF);
      S_WORD:  w_tx = w_shift[11] ^ (w_cnt >= C_HALF);
      S_END:   w_tx = 1'b1;
      default: w_tx = 1'b0;
    endcase

    w_active = (w_state != S_IDLE);
    w_ready  = !w_full && (w_state != S_END);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_bit    <= 4'd0;
      r_shift  <= 12'd0;
      r_hold   <= 10'd0;
      r_full   <= 1'b0;
      r_tx     <= 1'b0;
      r_active <= 1'b0;
      r_ready  <= 1'b1;
    end else begin
      r_state  <= w_state;
      r_cnt    <= w_cnt;
      r_bit    <= w_bit;
      r_shift  <= w_shift;
      r_hold   <= w_hold;
      r_full   <= w_full;
      r_tx     <= w_tx;
      r_active <= w_active;
      r_ready  <= w_ready;
    end
  end

  assign ready  = r_ready;
  assign active = r_active;
  assign tx     = r_tx;

endmodule

// File: tb/tb_coax_tx.sv
// Bench for coax_tx: directed frames, line decoder monitor against a scoreboard.
module tb_coax_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [9:0] data = 10'd0;
  logic       load_strobe = 1'b0;
  logic       ready;
  logic       active;
  logic       tx;

  int checks = 0;
  int failures = 0;

  logic [11:0] exp_words[$];
  int          exp_len[$];
  int          exp_nw[$];
  bit          samp [4000];

  always #5 clk = ~clk;

  coax_tx #(.CLOCKS_PER_BIT(16)) dut (
    .clk(clk),
    .reset(reset),
    .data(data),
    .load_strobe(load_strobe),
    .ready(ready),
    .active(active),
    .tx(tx)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: capture each active frame and decode it against the scoreboard.
  initial begin : monitor
    int len, nw, el, bad, base;
    bit a, e;
    logic [11:0] got, ew;
    forever begin
      @(negedge clk);
      if (active === 1'b1) begin
        len = 0;
        while (active === 1'b1 && len < 4000) begin
          samp[len] = tx;
          len++;
          @(negedge clk);
        end
        if (exp_len.size() == 0) begin
          check("unexpected_frame_len", len, 0);
        end else begin
          el = exp_len.pop_front();
          nw = exp_nw.pop_front();
          check("frame_len", len, el);
          if (nw > 0 && len == el) begin
            bad = 0;
            for (int i = 0; i < 80; i++) if (samp[i] != ((i % 16) < 8)) bad++;
            check("start_seq_errs", bad, 0);
            bad = 0;
            for (int i = 0; i < 48; i++) if (samp[80 + i] != (i < 24)) bad++;
            check("violation_errs", bad, 0);
            for (int k = 0; k < nw; k++) begin
              got = 12'd0;
              bad = 0;
              for (int j = 0; j < 12; j++) begin
                base = 128 + k * 192 + j * 16;
                a = samp[base];
                for (int h = 0; h < 16; h++) begin
                  e = (h < 8) ? a : !a;
                  if (samp[base + h] != e) bad++;
                end
                got = {got[10:0], a};
              end
              check("manchester_errs", bad, 0);
              ew = (exp_words.size() > 0) ? exp_words.pop_front() : 12'hFFF;
              check("word", int'(got), int'(ew));
            end
            bad = 0;
            for (int i = 0; i < 32; i++) if (samp[128 + nw * 192 + i] != 1'b1) bad++;
            check("end_seq_errs", bad, 0);
          end
        end
      end
    end
  end

  task automatic strobe(input logic [9:0] d);
    int t = 0;
    while (ready !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("ready_before_strobe", int'(ready === 1'b1), 1);
    data = d;
    load_strobe = 1'b1;
    @(negedge clk);
    load_strobe = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((active !== 1'b0 || ready !== 1'b1) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("idle_within_budget", int'(t < 3000), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic expect_frame(input int len, input int nw);
    exp_len.push_back(len);
    exp_nw.push_back(nw);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    repeat (3) @(negedge clk);
    check("reset_tx", int'(tx), 0);
    check("reset_active", int'(active), 0);
    check("reset_ready", int'(ready), 1);
    reset = 1'b1;
    @(negedge clk);

    // Single word 0x2A5 -> {1, 2A5, parity 1}
    expect_frame(352, 1);
    exp_words.push_back(12'hD4B);
    strobe(10'h2A5);
    check("active_latency", int'(active), 1);
    check("ready_while_held", int'(ready), 0);
    wait_idle();

    // Two chained words; a strobe while holding is full must be dropped
    expect_frame(544, 2);
    exp_words.push_back(12'hD4B);
    exp_words.push_back(12'h9FE);
    strobe(10'h2A5);
    repeat (150) @(negedge clk);
    strobe(10'h0FF);
    check("ready_holding_full", int'(ready), 0);
    data = 10'h155;
    load_strobe = 1'b1;
    @(negedge clk);
    load_strobe = 1'b0;
    wait_idle();

    // Abort after 100 active cycles, then a clean 0x001
    expect_frame(100, 0);
    strobe(10'h2A5);
    repeat (99) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("abort_tx", int'(tx), 0);
    check("abort_active", int'(active), 0);
    check("abort_ready", int'(ready), 1);
    reset = 1'b1;
    @(negedge clk);
    expect_frame(352, 1);
    exp_words.push_back(12'h803);
    strobe(10'h001);
    wait_idle();

    // Reset wins over a simultaneous strobe
    reset = 1'b0;
    data = 10'h155;
    load_strobe = 1'b1;
    @(negedge clk);
    load_strobe = 1'b0;
    check("reset_prio_active", int'(active), 0);
    check("reset_prio_ready", int'(ready), 1);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_prio_still_idle", int'(active), 0);

    // All-zero word
    expect_frame(352, 1);
    exp_words.push_back(12'h800);
    strobe(10'h000);
    wait_idle();

    check("words_left", exp_words.size(), 0);
    check("frames_left", exp_len.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/coax_tx.md
COAX_TX -- requirements
Module: coax_tx

Interface
REQ-001 SHALL have parameter CLOCKS_PER_BIT, default 16: clk cycles per coax bit time; even, >= 4.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset; 0 = reset, sampled on clk rising edge.
REQ-004 SHALL have port data  input  10  word to transmit, sampled when load_strobe=1 and ready=1.
REQ-005 SHALL have port load_strobe  input  1  one-cycle request to accept data.
REQ-006 SHALL have port ready  output  1  holding register empty; a word can be accepted this cycle.
REQ-007 SHALL have port active  output  1  high for every cycle a transmission (start through end sequence) is on the line.
REQ-008 SHALL have port tx  output  1  serial line drive, registered.

Function
REQ-009 SHALL hold one 10-bit holding register plus a 12-bit shift register; H = CLOCKS_PER_BIT/2 clocks is one half-bit.
REQ-010 SHALL accept data only when load_strobe=1 and ready=1; load_strobe with ready=0 is ignored with no state change.
REQ-011 SHALL drive ready = holding empty AND state != END.
REQ-012 SHALL use Manchester coding per bit: 1 = tx high for H then low for H; 0 = tx low for H then high for H.
REQ-013 SHALL implement states IDLE, START, VIOLATION, WORD, END.
REQ-014 IDLE: tx=0, active=0; an accept moves to START with first START clock on the next cycle (latency 1).
REQ-015 START: transmits five 1 bits (5*CLOCKS_PER_BIT clocks), then VIOLATION.
REQ-016 VIOLATION: tx high 3*H clocks, then low 3*H clocks, then WORD.
REQ-017 WORD entry: holding register moves into shift register as {1'b1 sync, data[9:0] MSB first, parity}; holding becomes empty that same cycle.
REQ-018 Parity bit SHALL make the count of ones in data[9:0] plus parity even.
REQ-019 WORD: shifts 12 bits, 12*CLOCKS_PER_BIT clocks; on the last clock of the parity bit, if holding is full, reloads and stays in WORD with no gap; else goes to END.
REQ-020 An accept on the same cycle as the reload check SHALL NOT be possible (ready=0 while holding full); an accept one cycle later waits for the next word boundary.
REQ-021 END: tx high for 2*CLOCKS_PER_BIT clocks, then tx=0, active=0, state IDLE next cycle.
REQ-022 active SHALL be 1 in START, VIOLATION, WORD, END and 0 in IDLE.
REQ-023 Bit and half-bit counters SHALL be sized for CLOCKS_PER_BIT*12 without overflow; wrap only by explicit reload at state/bit boundaries.
REQ-024 A word accepted while in START or VIOLATION SHALL be sent as the first word; accepts during WORD are queued in holding.

Reset
REQ-025 With reset=0 on a rising edge: state IDLE, holding empty, counters 0, tx=0, active=0, ready=1 from the next cycle.
REQ-026 Reset mid-transmission SHALL abort immediately; the partial word and any held word are discarded; line returns to tx=0.
REQ-027 Reset SHALL take priority over a simultaneous load_strobe.

Verification (CLOCKS_PER_BIT=16)
REQ-028 Single word 10'h2A5 from IDLE -> active high exactly 352 cycles (5+3+12+2 bits) starting the cycle after strobe; parity bit 1; ready returns to 1 when END completes.
REQ-029 Two words 10'h2A5 then 10'h0FF, second strobed during first WORD -> contiguous 24 word bits, no gap, active 544 cycles, parity bits 1 then 0.
REQ-030 Strobe with ready=0 (holding full) carrying 10'h155 -> word not transmitted; queued word unchanged.
REQ-031 reset=0 at cycle 100 of a transmission -> next cycle tx=0, active=0, ready=1; following 10'h001 transmits cleanly with parity 1.
REQ-032 VIOLATION waveform check -> after 80 START clocks, tx high 24 clocks then low 24 clocks, then sync bit high 8 / low 8.
REQ-033 All-zero word 10'h000 -> sync 1, ten 0 bits (low 8 / high 8 each), parity 0.
